// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: parses write/read command packets from a serial line,
// runs them as 32-bit memory bus transactions and answers on its own transmitter.
module uart_bus_master #(
    parameter int BAUD_DIVIDER = 694,
    parameter int BUS_TIMEOUT  = 1023,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    // state  | meaning
    // IDLE   | waiting for a command byte
    // CMD    | decode the latched command byte
    // ADDR   | collecting A0..A3
    // DATA   | collecting D0..D3 (writes only)
    // BUS    | mem_valid high, waiting for mem_ready or timeout
    // RESP   | sending response bytes, held until the last stop bit ends
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam int BW   = $clog2(BAUD_DIVIDER + 1);
    localparam int TMAX = (BYTE_TIMEOUT > BUS_TIMEOUT) ? BYTE_TIMEOUT : BUS_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIVIDER);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIVIDER / 2);
    localparam logic [TW-1:0] BUS_LOAD  = TW'(BUS_TIMEOUT - 1);
    localparam logic [TW-1:0] BYTE_LOAD = TW'(BYTE_TIMEOUT - 1);
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    state_t          state, state_n;
    logic            rxd_m, rxd_s, rxd_q;
    logic            rx_active, rx_strobe, rx_ferr;
    logic [BW-1:0]   rx_cnt;
    logic [3:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            tx_active, tx_start, tx_last, tx_ready;
    logic [BW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;
    logic [9:0]      tx_shift;
    logic [7:0]      cmd_byte;
    logic            is_write;
    logic [1:0]      byte_cnt;
    logic [TW-1:0]   tmr, tmr_val;
    logic            tmr_load, resp_load;
    logic [31:0]     resp_data, resp_val;
    logic [2:0]      resp_cnt, resp_len;

    assign mem_instr = 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) {rxd_m, rxd_s, rxd_q} <= 3'b111;
        else         {rxd_m, rxd_s, rxd_q} <= {uart_rxd, rxd_m, rxd_s};
    end

    // Receiver: bit 0 is the start sample, bits 1..8 data, bit 9 stop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_strobe <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            rx_ferr   <= 1'b0;
            if (!rx_active) begin
                if (rxd_q && !rxd_s) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= BAUD_HALF;
                    rx_bit    <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - BW'(1);
            end else begin
                rx_cnt <= BAUD_FULL;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rxd_s) rx_active <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_strobe <= rxd_s;
                    rx_ferr   <= !rxd_s;
                end else begin
                    rx_shift <= {rxd_s, rx_shift[7:1]};
                end
            end
        end
    end

    // A new byte may be loaded on the last stop-bit cycle so responses go out gap-free.
    assign tx_last  = tx_active && (tx_cnt == '0) && (tx_bit == 4'd9);
    assign tx_ready = !tx_active || tx_last;
    assign uart_txd = tx_shift[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '1;
        end else if (tx_start) begin
            tx_active <= 1'b1;
            tx_cnt    <= BAUD_FULL;
            tx_bit    <= '0;
            tx_shift  <= {1'b1, resp_data[7:0], 1'b0};
        end else if (tx_active) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - BW'(1);
            end else if (tx_bit == 4'd9) begin
                tx_active <= 1'b0;
            end else begin
                tx_cnt   <= BAUD_FULL;
                tx_bit   <= tx_bit + 4'd1;
                tx_shift <= {1'b1, tx_shift[9:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tx_start  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = BYTE_LOAD;
        resp_load = 1'b0;
        resp_val  = 32'h15;
        resp_len  = 3'd1;
        case (state)
            S_IDLE: if (rx_strobe) begin
                state_n  = S_CMD;
                tmr_load = 1'b1;
            end
            S_CMD: begin
                if (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ) begin
                    state_n = S_ADDR;
                end else begin
                    state_n   = S_RESP;
                    resp_load = 1'b1;
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_ferr || (!rx_strobe && tmr == '0)) begin
                    state_n = S_IDLE;
                end else if (rx_strobe) begin
                    tmr_load = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        if (state == S_ADDR && is_write) begin
                            state_n = S_DATA;
                        end else begin
                            state_n = S_BUS;
                            tmr_val = BUS_LOAD;
                        end
                    end
                end
            end
            S_BUS: begin
                if (mem_ready) begin
                    state_n   = S_RESP;
                    resp_load = 1'b1;
                    resp_val  = is_write ? 32'h06 : mem_rdata;
                    resp_len  = is_write ? 3'd1 : 3'd4;
                end else if (tmr == '0) begin
                    state_n   = S_RESP;
                    resp_load = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_cnt != 3'd0) tx_start = tx_ready;
                else if (tx_last)     state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_byte  <= '0;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tmr       <= '0;
            resp_data <= '0;
            resp_cnt  <= '0;
            mem_valid <= 1'b0;
            mem_wstrb <= '0;
            busy      <= 1'b0;
        end else begin
            mem_valid <= (state_n == S_BUS);
            mem_wstrb <= (state_n == S_BUS && is_write) ? 4'hF : 4'h0;
            busy      <= (state_n != S_IDLE);
            if (tmr_load)        tmr <= tmr_val;
            else if (tmr != '0)  tmr <= tmr - TW'(1);
            if (state == S_IDLE && rx_strobe) cmd_byte <= rx_shift;
            if (state == S_CMD) begin
                is_write <= (cmd_byte == CMD_WRITE);
                byte_cnt <= '0;
            end
            if (rx_strobe && state == S_ADDR) begin
                mem_addr <= {rx_shift, mem_addr[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (rx_strobe && state == S_DATA) begin
                mem_wdata <= {rx_shift, mem_wdata[31:8]};
                byte_cnt  <= byte_cnt + 2'd1;
            end
            if (resp_load) begin
                resp_data <= resp_val;
                resp_cnt  <= resp_len;
            end else if (tx_start) begin
                resp_data <= {8'h00, resp_data[31:8]};
                resp_cnt  <= resp_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: vector table of packets plus hand-written
// corner sequences, with bus and serial-response scoreboards.
module tb_uart_bus_master;
    localparam int BD  = 15;
    localparam int BIT = BD + 1;

    logic        clk = 1'b0, resetn = 1'b0, uart_rxd = 1'b1, mem_ready = 1'b0;
    logic        uart_txd, mem_valid, mem_instr, busy;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;

    uart_bus_master #(.BAUD_DIVIDER(BD), .BUS_TIMEOUT(8), .BYTE_TIMEOUT(200)) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          vlen;
    } bus_exp_t;

    typedef struct {
        int          nb;
        logic [71:0] pkt;
        int          wait_cyc;
        logic [31:0] rdata;
        bit          exp_bus;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [3:0]  ewstrb;
        int          evlen;
        int          ntx;
        logic [31:0] etx;
    } vec_t;

    bus_exp_t    exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          tx_starts[$];
    int          checks = 0, errors = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_rdata = 32'h0;
    bit          bus_ignore = 1'b0;
    int          valid_fall_cyc = 0;
    int          bus_txns = 0;
    vec_t        vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Bus responder and request monitor.
    initial begin : bus_mon
        int vcnt;
        logic [31:0] a, d;
        logic [3:0] s;
        bit stable;
        bus_exp_t e;
        vcnt = 0; a = '0; d = '0; s = '0; stable = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (vcnt == 0) begin
                    a = mem_addr; d = mem_wdata; s = mem_wstrb; stable = 1'b1;
                end else if (mem_addr !== a || mem_wdata !== d || mem_wstrb !== s) begin
                    stable = 1'b0;
                end
                vcnt++;
                mem_ready = (rsp_wait >= 0) && (vcnt > rsp_wait);
                mem_rdata = mem_ready ? rsp_rdata : 32'h0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'h0;
                if (vcnt > 0) begin
                    valid_fall_cyc = cyc;
                    if (!bus_ignore) begin
                        bus_txns++;
                        chk("bus_pending", exp_bus.size() != 0, 1);
                        if (exp_bus.size() != 0) begin
                            e = exp_bus.pop_front();
                            chk("mem_addr", a, e.addr);
                            chk("mem_wstrb", s, e.wstrb);
                            if (e.wstrb == 4'hF) chk("mem_wdata", d, e.wdata);
                            chk("valid_cycles", vcnt, e.vlen);
                            chk("req_stable", stable, 1);
                        end
                    end
                    vcnt = 0;
                end
            end
        end
    end

    // Serial response decoder.
    initial begin : tx_mon
        logic [7:0] b;
        logic stp, sb;
        @(posedge resetn);
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                tx_starts.push_back(cyc);
                repeat (BIT / 2) @(negedge clk);
                sb = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (BIT) @(negedge clk);
                stp = uart_txd;
                chk("tx_start_bit", sb, 0);
                chk("tx_stop_bit", stp, 1);
                chk("tx_pending", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("tx_byte", b, exp_tx.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic wait_busy_low(input int budget, output int fall_cyc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall_in_time", n < budget, 1);
        fall_cyc = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        int fall, lat;
        bus_exp_t e;
        rsp_wait  = v.wait_cyc;
        rsp_rdata = v.rdata;
        if (v.exp_bus) begin
            e.addr = v.eaddr; e.wdata = v.ewdata; e.wstrb = v.ewstrb; e.vlen = v.evlen;
            exp_bus.push_back(e);
        end
        for (int i = 0; i < v.ntx; i++) exp_tx.push_back(v.etx[8*i +: 8]);
        tx_starts.delete();
        chk("busy_idle_before", busy, 0);
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.pkt[8*i +: 8], 1'b1);
            if (i == 0) chk("busy_after_cmd", busy, 1);
        end
        wait_busy_low(3000, fall);
        chk("tx_byte_count", tx_starts.size(), v.ntx);
        if (tx_starts.size() == v.ntx && v.ntx > 0) begin
            chk("resp_length", fall - tx_starts[0], v.ntx * 10 * BIT);
            if (v.ntx > 1)
                chk("back_to_back", tx_starts[v.ntx-1] - tx_starts[0], (v.ntx - 1) * 10 * BIT);
            if (v.exp_bus) begin
                lat = tx_starts[0] - valid_fall_cyc;
                chk("resp_latency", (lat >= 1) && (lat <= 2), 1);
            end
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0, n;
        vecs[0] = '{nb: 9, pkt: {32'hDEADBEEF, 32'h80000010, 8'h57}, wait_cyc: 3, rdata: 32'h0,
                    exp_bus: 1'b1, eaddr: 32'h80000010, ewdata: 32'hDEADBEEF, ewstrb: 4'hF,
                    evlen: 4, ntx: 1, etx: 32'h06};
        vecs[1] = '{nb: 5, pkt: {32'h0, 32'h40000004, 8'h52}, wait_cyc: 0, rdata: 32'h12345678,
                    exp_bus: 1'b1, eaddr: 32'h40000004, ewdata: 32'h0, ewstrb: 4'h0,
                    evlen: 1, ntx: 4, etx: 32'h12345678};
        vecs[2] = '{nb: 5, pkt: {32'h0, 32'h00000020, 8'h52}, wait_cyc: -1, rdata: 32'h0,
                    exp_bus: 1'b1, eaddr: 32'h00000020, ewdata: 32'h0, ewstrb: 4'h0,
                    evlen: 8, ntx: 1, etx: 32'h15};
        vecs[3] = '{nb: 1, pkt: {64'h0, 8'h41}, wait_cyc: 0, rdata: 32'h0,
                    exp_bus: 1'b0, eaddr: 32'h0, ewdata: 32'h0, ewstrb: 4'h0,
                    evlen: 0, ntx: 1, etx: 32'h15};
        vecs[4] = '{nb: 9, pkt: {32'hCAFEF00D, 32'h00001234, 8'h57}, wait_cyc: 0, rdata: 32'h0,
                    exp_bus: 1'b1, eaddr: 32'h00001234, ewdata: 32'hCAFEF00D, ewstrb: 4'hF,
                    evlen: 1, ntx: 1, etx: 32'h06};
        vecs[5] = '{nb: 5, pkt: {32'h0, 32'h10000008, 8'h52}, wait_cyc: 7, rdata: 32'hA5A55A5A,
                    exp_bus: 1'b1, eaddr: 32'h10000008, ewdata: 32'h0, ewstrb: 4'h0,
                    evlen: 8, ntx: 4, etx: 32'hA5A55A5A};
        vecs[6] = '{nb: 9, pkt: {32'h01020304, 32'h2000000C, 8'h57}, wait_cyc: 7, rdata: 32'h0,
                    exp_bus: 1'b1, eaddr: 32'h2000000C, ewdata: 32'h01020304, ewstrb: 4'hF,
                    evlen: 8, ntx: 1, etx: 32'h06};

        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_valid", mem_valid, 0);
        chk("rst_instr", mem_instr, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // A one-cycle low glitch must not start a byte.
        n0 = bus_txns;
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy", busy, 0);
        chk("glitch_no_bus", bus_txns, n0);

        // Framing error in the middle of the address drops the packet.
        n0 = bus_txns;
        send_byte(8'h57, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_busy", busy, 0);
        run_vec(vecs[0]);
        chk("ferr_bus_count", bus_txns, n0 + 1);

        // Inter-byte timeout drops a partial write.
        n0 = bus_txns;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (300) @(negedge clk);
        chk("bto_busy", busy, 0);
        run_vec(vecs[1]);
        chk("bto_bus_count", bus_txns, n0 + 1);

        // Reset while mem_valid is high.
        rsp_wait   = -1;
        bus_ignore = 1'b1;
        send_byte(8'h52, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        fork
            send_byte(8'h40, 1'b1);
        join_none
        n = 0;
        while (mem_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_valid_seen", mem_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_valid", mem_valid, 0);
        chk("rst_mid_txd", uart_txd, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wstrb", mem_wstrb, 0);
        repeat (40) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        bus_ignore = 1'b0;
        n0 = bus_txns;
        run_vec(vecs[0]);
        chk("rst_mid_bus_count", bus_txns, n0 + 1);

        repeat (50) @(negedge clk);
        chk("exp_tx_left", exp_tx.size(), 0);
        chk("exp_bus_left", exp_bus.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
